// File: rtl/wb_sram_bridge_if.sv
// Wishbone classic bus between the SoC master and the SRAM bridge slave.
// Signal suffixes are named from the slave's point of view.
interface wb_sram_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i,
        output wb_stb_i,
        output wb_we_i,
        output wb_sel_i,
        output wb_adr_i,
        output wb_dat_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_err_o
    );

    modport slave (
        input  wb_cyc_i,
        input  wb_stb_i,
        input  wb_we_i,
        input  wb_sel_i,
        input  wb_adr_i,
        input  wb_dat_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_err_o
    );
endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave driving a synchronous-read byte-writable SRAM; misses get err.
// Write/miss: ack/err 1 cycle after stb; read: ack 2 cycles after stb; stalls the master via ack only.
module wb_sram_bridge #(
    parameter int          COLS      = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         A_WIDTH   = 8 + $clog2(COLS)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_sram_bridge_if.slave    wb,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [A_WIDTH-1:0] ram_a,
    output logic [31:0]        ram_di,
    input  logic [31:0]        ram_do
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;

    logic req;
    logic hit;
    logic unused_adr_lsb;

    assign req = wb.wb_cyc_i & wb.wb_stb_i;
    assign hit = (wb.wb_adr_i[31:A_WIDTH+2] == BASE_ADDR[31:A_WIDTH+2]);
    assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

    // The RAM is only touched from IDLE, so a stb held through RD/RESP is never re-issued.
    assign ram_en = ~wb_rst_i & (state_q == S_IDLE) & req & hit;
    assign ram_we = (ram_en && wb.wb_we_i) ? wb.wb_sel_i : 4'b0000;
    assign ram_a  = wb.wb_adr_i[A_WIDTH+1:2];
    assign ram_di = wb.wb_dat_i;

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!hit) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (wb.wb_we_i) begin
                        ack_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                // ram_do is only meaningful here; elsewhere the macro drives zero.
                if (wb.wb_cyc_i) begin
                    dat_d   = ram_do;
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;

    a_ack_err_excl: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        !(ack_q && err_q));
    a_resp_single: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        (ack_q || err_q) |=> !(ack_q || err_q));
    a_en_idle_only: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        ram_en |-> (state_q == S_IDLE));

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge (COLS=2, window at 0x0100_0000) with a behavioural DFFRAM.
module tb_wb_sram_bridge;
    localparam int          COLS = 2;
    localparam int          AW   = 9;
    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [AW-1:0] ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do = 32'h0;
    logic [31:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt   = 0;
    int en_viol  = 0;

    wb_sram_bridge_if bus ();

    wb_sram_bridge #(.COLS(COLS), .BASE_ADDR(BASE)) u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_a    (ram_a),
        .ram_di   (ram_di),
        .ram_do   (ram_do)
    );

    always #5 clk = ~clk;

    // DFFRAM model: registered read, byte writes, Do forced to 0 when not enabled.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
            ram_do <= mem[ram_a];
        end else begin
            ram_do <= 32'h0;
        end
    end

    always @(negedge clk) begin
        if (ram_en === 1'b1) en_cnt++;
        if (ram_en === 1'b1 && (bus.wb_ack_o || bus.wb_err_o)) en_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the edge that raised ack/err.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output int lat, output logic [1:0] resp);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        lat  = 0;
        resp = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o || bus.wb_err_o) begin
                lat  = i;
                resp = {bus.wb_ack_o, bus.wb_err_o};
                break;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int          lat;
        logic [1:0]  resp;
        int          en0;
        int          ack_cyc [4];
        int          n_ack;
        logic [31:0] rd_exp [4];

        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_sel_i = 4'h0; bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0;

        vecs[0]  = '{1'b1, BASE + 32'h014, 32'hDEADBEEF, 4'hF, 1'b0, 1, 32'h0000_0000};
        vecs[1]  = '{1'b0, BASE + 32'h014, 32'h0,        4'hF, 1'b0, 2, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, BASE + 32'h020, 32'h11223344, 4'hF, 1'b0, 1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, BASE + 32'h020, 32'hAABBCCDD, 4'h5, 1'b0, 1, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, BASE + 32'h020, 32'h0,        4'hF, 1'b0, 2, 32'h11BB33DD};
        vecs[5]  = '{1'b1, BASE + 32'h020, 32'hFFFFFFFF, 4'h0, 1'b0, 1, 32'h11BB33DD};
        vecs[6]  = '{1'b0, BASE + 32'h020, 32'h0,        4'hF, 1'b0, 2, 32'h11BB33DD};
        vecs[7]  = '{1'b0, 32'h0200_0010,  32'h0,        4'hF, 1'b1, 1, 32'h11BB33DD};
        vecs[8]  = '{1'b1, 32'h0200_0010,  32'h12345678, 4'hF, 1'b1, 1, 32'h11BB33DD};
        vecs[9]  = '{1'b1, BASE + 32'h7FC, 32'h5A5A0001, 4'hF, 1'b0, 1, 32'h11BB33DD};
        vecs[10] = '{1'b1, BASE + 32'h000, 32'hC0DE0000, 4'hF, 1'b0, 1, 32'h11BB33DD};
        vecs[11] = '{1'b1, BASE + 32'h004, 32'hC0DE0001, 4'hF, 1'b0, 1, 32'h11BB33DD};
        vecs[12] = '{1'b1, BASE + 32'h008, 32'hC0DE0002, 4'hF, 1'b0, 1, 32'h11BB33DD};
        vecs[13] = '{1'b1, BASE + 32'h00C, 32'hC0DE0003, 4'hF, 1'b0, 1, 32'h11BB33DD};
        vecs[14] = '{1'b0, BASE + 32'h7FC, 32'h0,        4'hF, 1'b0, 2, 32'h5A5A0001};
        vecs[15] = '{1'b0, BASE + 32'h000, 32'h0,        4'hF, 1'b0, 2, 32'hC0DE0000};

        // Reset with a live hit request on the bus: RAM must stay untouched.
        repeat (2) @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b1;
        bus.wb_adr_i = BASE + 32'h010; bus.wb_sel_i = 4'hF;
        @(negedge clk);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rst_ram_we", {28'h0, ram_we}, 32'h0);
        check("rst_ack",    {31'h0, bus.wb_ack_o}, 32'h0);
        check("rst_err",    {31'h0, bus.wb_err_o}, 32'h0);
        check("rst_dat",    bus.wb_dat_o, 32'h0);
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            en0 = en_cnt;
            xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, lat, resp);
            check($sformatf("v%0d_resp", i), {30'h0, resp},
                  vecs[i].exp_err ? 32'h1 : 32'h2);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_dat", i), bus.wb_dat_o, vecs[i].exp_dat);
            check($sformatf("v%0d_ram_acc", i), en_cnt - en0, vecs[i].exp_err ? 0 : 1);
            @(posedge clk); #1;
            check($sformatf("v%0d_resp_1cyc", i), {30'h0, bus.wb_ack_o, bus.wb_err_o}, 32'h0);
        end

        // Four reads of words 0..3 with cyc/stb held high; address advances on each ack.
        rd_exp[0] = 32'hC0DE0000; rd_exp[1] = 32'hC0DE0001;
        rd_exp[2] = 32'hC0DE0002; rd_exp[3] = 32'hC0DE0003;
        en0   = en_cnt;
        n_ack = 0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = BASE;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o) begin
                if (n_ack < 4) begin
                    ack_cyc[n_ack] = k;
                    check($sformatf("b2b_dat%0d", n_ack), bus.wb_dat_o, rd_exp[n_ack]);
                end
                n_ack++;
                if (n_ack < 4) bus.wb_adr_i = BASE + 32'(4 * n_ack);
                else begin
                    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
                end
            end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        check("b2b_acks", n_ack, 4);
        if (n_ack >= 4) begin
            check("b2b_first", ack_cyc[0], 2);
            for (int j = 1; j < 4; j++)
                check($sformatf("b2b_gap%0d", j), ack_cyc[j] - ack_cyc[j-1], 3);
        end
        check("b2b_ram_acc", en_cnt - en0, 4);
        @(posedge clk); #1;

        // Abort: cyc dropped in RD.
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = BASE + 32'h004;
        @(posedge clk); #1;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        @(posedge clk); #1;
        check("abort_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("abort_dat", bus.wb_dat_o, 32'hC0DE0003);
        xfer(1'b0, BASE + 32'h008, 32'h0, 4'hF, lat, resp);
        check("abort_next_lat", lat, 2);
        check("abort_next_dat", bus.wb_dat_o, 32'hC0DE0002);
        @(posedge clk); #1;

        // Reset asserted in RD with the request still held.
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = BASE + 32'h00C;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstrd_ack",  {31'h0, bus.wb_ack_o}, 32'h0);
        check("rstrd_err",  {31'h0, bus.wb_err_o}, 32'h0);
        check("rstrd_dat",  bus.wb_dat_o, 32'h0);
        check("rstrd_en",   {31'h0, ram_en}, 32'h0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, BASE + 32'h00C, 32'h0, 4'hF, lat, resp);
        check("rstrd_next_lat", lat, 2);
        check("rstrd_next_dat", bus.wb_dat_o, 32'hC0DE0003);
        @(posedge clk); #1;

        // Reset in RESP after a write: write stays committed.
        xfer(1'b1, BASE + 32'h010, 32'h44440004, 4'hF, lat, resp);
        check("rstresp_wr_lat", lat, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstresp_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("rstresp_dat", bus.wb_dat_o, 32'h0);
        rst = 1'b0;
        xfer(1'b0, BASE + 32'h010, 32'h0, 4'hF, lat, resp);
        check("rstresp_rd_lat", lat, 2);
        check("rstresp_rd_dat", bus.wb_dat_o, 32'h44440004);
        @(posedge clk); #1;

        check("ram_en_in_resp", en_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
